command_tokenizer: RTL and testbench

Converts a raw ASCII byte stream of rotation commands ("L68\nR48\n...") into one decoded token per command: a direction bit and a binary magnitude. It sits directly upstream of the dial-rotation stage, replacing file-based command parsing with a synthesizable valid/ready byte interface. The stage consumes one byte per cycle and presents each token on a registered valid/ready output.

---
 rtl/cmd_pkg.sv | 34 +++
 rtl/dec_accum.sv | 23 ++
 rtl/command_tokenizer.sv | 158 +++++++++++++++
 tb/tb_command_tokenizer.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_pkg.sv
// Shared definitions for the rotation-command tokenizer and the dial-rotation stage.
// Direction encoding, ASCII constants, tokenizer state type and default magnitude width.
package cmd_pkg;

    localparam int MAG_W_DEF = 32;

    localparam logic DIR_L = 1'b0;
    localparam logic DIR_R = 1'b1;

    localparam logic [7:0] CH_L   = 8'h4C;
    localparam logic [7:0] CH_R   = 8'h52;
    localparam logic [7:0] CH_0   = 8'h30;
    localparam logic [7:0] CH_9   = 8'h39;
    localparam logic [7:0] CH_SP  = 8'h20;
    localparam logic [7:0] CH_TAB = 8'h09;
    localparam logic [7:0] CH_LF  = 8'h0A;
    localparam logic [7:0] CH_CR  = 8'h0D;

    typedef enum logic [1:0] {
        IDLE,
        DIGITS,
        EMIT,
        SKIP
    } tok_state_t;

    function automatic logic is_ws(input logic [7:0] c);
        return (c == CH_SP) || (c == CH_TAB) || (c == CH_LF) || (c == CH_CR);
    endfunction

    function automatic logic is_digit(input logic [7:0] c);
        return (c >= CH_0) && (c <= CH_9);
    endfunction

endpackage

// File: rtl/dec_accum.sv
// Decimal accumulate step: acc*10 + digit, clamped to all-ones when it
// no longer fits in MAG_W bits.
module dec_accum
    import cmd_pkg::*;
#(
    parameter int MAG_W = MAG_W_DEF
) (
    input  logic [MAG_W-1:0] acc_i,
    input  logic [3:0]       digit_i,
    output logic [MAG_W-1:0] sum_o,
    output logic             sat_o
);

    logic [MAG_W+3:0] acc_w;
    logic [MAG_W+3:0] wide;

    // Four spare bits hold acc*10+9 for any acc, so overflow is visible.
    assign acc_w = {4'b0000, acc_i};
    assign wide  = (acc_w << 3) + (acc_w << 1) + {{MAG_W{1'b0}}, digit_i};
    assign sat_o = |wide[MAG_W+3:MAG_W];
    assign sum_o = sat_o ? '1 : wide[MAG_W-1:0];

endmodule

// File: rtl/command_tokenizer.sv
// ASCII rotation-command stream to (dir, magnitude) tokens over valid/ready.
// Define TOKENIZER_STATS_EN to add the tok_count / err_count statistics outputs.
module command_tokenizer
    import cmd_pkg::*;
#(
    parameter int MAG_W = MAG_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_last,
    output logic             tok_dir,
    output logic [MAG_W-1:0] tok_mag,
    output logic             tok_valid,
    input  logic             tok_ready,
    output logic             tok_last,
    output logic             err,
`ifdef TOKENIZER_STATS_EN
    output logic [31:0]      tok_count,
    output logic [15:0]      err_count,
`endif
    output logic             ovf
);

    tok_state_t       state_q, state_d;
    logic             dir_q, dir_d;
    logic [MAG_W-1:0] acc_q, acc_d;
    logic             seen_q, seen_d;
    logic             last_q, last_d;
    logic             err_q, err_d;
    logic             ovf_q, ovf_d;
    logic             err_evt;

    logic             accept;
    logic             ws;
    logic             dig;
    logic             dirc;
    logic [MAG_W-1:0] sum;
    logic             sat;

    assign accept = in_valid && in_ready;
    assign ws     = is_ws(in_data);
    assign dig    = is_digit(in_data);
    assign dirc   = (in_data == CH_L) || (in_data == CH_R);

    dec_accum #(.MAG_W(MAG_W)) u_acc (
        .acc_i   (acc_q),
        .digit_i (in_data[3:0]),
        .sum_o   (sum),
        .sat_o   (sat)
    );

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        acc_d   = acc_q;
        seen_d  = seen_q;
        last_d  = last_q;
        ovf_d   = ovf_q;
        err_evt = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept && !ws) begin
                    if (dirc) begin
                        dir_d   = (in_data == CH_R) ? DIR_R : DIR_L;
                        acc_d   = '0;
                        seen_d  = 1'b0;
                        state_d = in_last ? IDLE : DIGITS;
                    end else begin
                        err_evt = 1'b1;
                        state_d = in_last ? IDLE : SKIP;
                    end
                end
            end
            DIGITS: begin
                if (accept) begin
                    if (dig) begin
                        acc_d  = sum;
                        ovf_d  = ovf_q | sat;
                        seen_d = 1'b1;
                        if (in_last) begin
                            state_d = EMIT;
                            last_d  = 1'b1;
                        end
                    end else if (ws && seen_q) begin
                        state_d = EMIT;
                        last_d  = in_last;
                    end else if (ws) begin
                        err_evt = 1'b1;
                        state_d = IDLE;
                    end else begin
                        err_evt = 1'b1;
                        state_d = in_last ? IDLE : SKIP;
                    end
                end
            end
            SKIP: begin
                if (accept && (ws || in_last)) state_d = IDLE;
            end
            EMIT: begin
                if (tok_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign err_d = err_q | err_evt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            dir_q   <= DIR_L;
            acc_q   <= '0;
            seen_q  <= 1'b0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            acc_q   <= acc_d;
            seen_q  <= seen_d;
            last_q  <= last_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
        end
    end

    // Token fields are the working registers themselves; they are frozen in EMIT.
    assign in_ready  = (state_q != EMIT);
    assign tok_valid = (state_q == EMIT);
    assign tok_dir   = dir_q;
    assign tok_mag   = acc_q;
    assign tok_last  = last_q;
    assign err       = err_q;
    assign ovf       = ovf_q;

`ifdef TOKENIZER_STATS_EN
    logic [31:0] tok_cnt_q;
    logic [15:0] err_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tok_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            if (tok_valid && tok_ready) tok_cnt_q <= tok_cnt_q + 32'd1;
            if (err_evt && (err_cnt_q != 16'hFFFF)) err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign tok_count = tok_cnt_q;
    assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_command_tokenizer.sv
// Scoreboard bench for command_tokenizer: directed streams plus random
// command streams checked against a word-level reference model.
module tb_command_tokenizer;

    localparam longint MAXV = 64'd4294967295;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_last = 1'b0;
    logic        tok_dir;
    logic [31:0] tok_mag;
    logic        tok_valid;
    logic        tok_ready = 1'b0;
    logic        tok_last;
    logic        err;
    logic        ovf;
`ifdef TOKENIZER_STATS_EN
    logic [31:0] tok_count;
    logic [15:0] err_count;
`endif

    command_tokenizer #(.MAG_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .tok_dir   (tok_dir),
        .tok_mag   (tok_mag),
        .tok_valid (tok_valid),
        .tok_ready (tok_ready),
        .tok_last  (tok_last),
        .err       (err),
`ifdef TOKENIZER_STATS_EN
        .tok_count (tok_count),
        .err_count (err_count),
`endif
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        dir;
        logic [31:0] mag;
        logic        last;
    } tok_t;

    tok_t         exp_q[$];
    byte unsigned stim[$];
    bit           m_err = 0;
    bit           m_ovf = 0;
    int           checks = 0;
    int           failures = 0;
    int           rdy_mode = 0;
    byte unsigned wsb[4] = '{8'h20, 8'h09, 8'h0A, 8'h0D};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic bit ws_c(input byte unsigned c);
        return c == 8'h20 || c == 8'h09 || c == 8'h0A || c == 8'h0D;
    endfunction

    function automatic bit dig_c(input byte unsigned c);
        return c >= 8'h30 && c <= 8'h39;
    endfunction

    // Word-level model: split on whitespace, each word is a command or junk.
    task automatic model_stream();
        int n;
        int i;
        int j;
        int k;
        longint v;
        tok_t t;
        n = stim.size();
        i = 0;
        while (i < n) begin
            if (ws_c(stim[i])) begin
                i++;
            end else begin
                j = i;
                while (j < n && !ws_c(stim[j])) j++;
                if (stim[i] == 8'h4C || stim[i] == 8'h52) begin
                    v = 0;
                    k = i + 1;
                    while (k < j && dig_c(stim[k])) begin
                        v = v * 10 + longint'(stim[k] - 8'h30);
                        if (v > MAXV) begin
                            v = MAXV;
                            m_ovf = 1;
                        end
                        k++;
                    end
                    if (k == j && j - i >= 2) begin
                        t.dir  = (stim[i] == 8'h52);
                        t.mag  = v[31:0];
                        t.last = (j >= n - 1);
                        exp_q.push_back(t);
                    end else if (!(j - i == 1 && j == n)) begin
                        m_err = 1;
                    end
                end else begin
                    m_err = 1;
                end
                i = j;
            end
        end
    endtask

    task automatic send_byte(input byte unsigned b, input bit last, input bit gaps);
        int guard;
        if (gaps) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        in_data  = b;
        in_valid = 1'b1;
        in_last  = last;
        guard    = 0;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                break;
            end
            guard++;
            if (guard > 500) begin
                checks++;
                failures++;
                $display("FAIL in_ready_timeout actual=0 required=1");
                break;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_stream(input bit use_model, input bit mark_last, input bit gaps);
        int n;
        n = stim.size();
        if (use_model) model_stream();
        for (int k = 0; k < n; k++) send_byte(stim[k], mark_last && (k == n - 1), gaps);
    endtask

    task automatic set_str(input string s);
        stim.delete();
        for (int k = 0; k < s.len(); k++) stim.push_back(s[k]);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 || tok_valid) begin
            @(posedge clk);
            #1;
            guard++;
            if (guard > 1000) begin
                checks++;
                failures++;
                $display("FAIL drain_timeout actual=%0d required=0", exp_q.size());
                exp_q.delete();
                break;
            end
        end
        chk("err_flag", 64'(err), 64'(m_err));
        chk("ovf_flag", 64'(ovf), 64'(m_ovf));
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: tok_ready = 1'b1;
                1: tok_ready = ($urandom_range(0, 3) != 0);
                default: tok_ready = 1'b0;
            endcase
        end
    end

    // Monitor: pops on every token handshake, checks stability while stalled.
    initial begin
        tok_t e;
        tok_t held;
        bit   held_v;
        held_v = 0;
        held   = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                held_v = 0;
            end else if (tok_valid) begin
                if (held_v) chk("stall_stable", 64'({tok_dir, tok_mag, tok_last}), 64'(held));
                if (tok_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_token actual=%0h required=none",
                                 {tok_dir, tok_mag, tok_last});
                    end else begin
                        e = exp_q.pop_front();
                        chk("token", 64'({tok_dir, tok_mag, tok_last}), 64'(e));
                    end
                    held_v = 0;
                end else begin
                    held   = {tok_dir, tok_mag, tok_last};
                    held_v = 1;
                end
            end else begin
                held_v = 0;
            end
        end
    end

    initial begin
        int nw;
        int r;
        int nd;
        rdy_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_tok_valid", 64'(tok_valid), 64'd0);
        chk("rst_tok_dir", 64'(tok_dir), 64'd0);
        chk("rst_tok_mag", 64'(tok_mag), 64'd0);
        chk("rst_tok_last", 64'(tok_last), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Two commands, token one cycle after each terminator
        set_str("L68\nR48\n");
        model_stream();
        for (int k = 0; k < 8; k++) begin
            send_byte(stim[k], k == 7, 1'b0);
            if (k == 3 || k == 7) chk("latency_valid", 64'(tok_valid), 64'd1);
        end
        drain();

        set_str("R5");
        send_stream(1'b1, 1'b1, 1'b0);
        drain();

        // Reset in the middle of a token drops it
        set_str("R12");
        send_stream(1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        chk("midrst_tok_valid", 64'(tok_valid), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        rst   = 1'b0;
        m_err = 0;
        m_ovf = 0;
        set_str("L1\n");
        send_stream(1'b1, 1'b1, 1'b0);
        drain();

        set_str("L4294967295\n");
        send_stream(1'b1, 1'b1, 1'b0);
        drain();

        // Consumer stall: input must back-pressure, token must hold
        rdy_mode = 2;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        set_str("L3\nR4\n");
        model_stream();
        for (int k = 0; k < 6; k++) begin
            send_byte(stim[k], k == 5, 1'b0);
            if (k == 2) begin
                repeat (5) begin
                    @(negedge clk);
                    chk("stall_in_ready", 64'(in_ready), 64'd0);
                    chk("stall_tok_valid", 64'(tok_valid), 64'd1);
                end
                rdy_mode = 0;
            end
        end
        drain();

        set_str("X12 L7\n");
        send_stream(1'b1, 1'b1, 1'b0);
        drain();

        set_str("R99999999999\n");
        send_stream(1'b1, 1'b1, 1'b0);
        drain();

        // Random streams with input gaps and random consumer back-pressure
        rdy_mode = 1;
        for (int s = 0; s < 40; s++) begin
            stim.delete();
            if ($urandom_range(0, 3) == 0) stim.push_back(wsb[$urandom_range(0, 3)]);
            nw = $urandom_range(1, 4);
            for (int w = 0; w < nw; w++) begin
                r = $urandom_range(0, 9);
                if (r < 7) begin
                    stim.push_back($urandom_range(0, 1) ? 8'h52 : 8'h4C);
                    nd = (r == 6) ? $urandom_range(9, 11) : $urandom_range(1, 4);
                    for (int d = 0; d < nd; d++) stim.push_back(8'(8'h30 + $urandom_range(0, 9)));
                end else if (r == 7) begin
                    stim.push_back(8'h6C);
                    stim.push_back(8'h35);
                end else if (r == 8) begin
                    stim.push_back(8'h4C);
                    stim.push_back(8'h31);
                    stim.push_back(8'h58);
                end else begin
                    stim.push_back(8'h23);
                    stim.push_back(8'h35);
                end
                if (w != nw - 1 || $urandom_range(0, 1) == 1) begin
                    repeat ($urandom_range(1, 2)) stim.push_back(wsb[$urandom_range(0, 3)]);
                end
            end
            send_stream(1'b1, 1'b1, 1'b1);
            drain();
        end

        rdy_mode = 0;
        repeat (4) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
